// File: rtl/inst_fetch_unit.sv
// Program counter and fetch stage in front of the instruction ROM: drives the ROM
// address, registers the returned word for the decoder and sequences IDLE/RUN/HALT.
module inst_fetch_unit #(
  parameter int               ADDR_W    = 8,
  parameter int               INST_W    = 10,
  parameter logic [INST_W-1:0] HALT_INST = '0,
  parameter bit               WRAP_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_off,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [15:0]       fetch_count,
  output logic [1:0]        dbgState
);

  // Handshake: inst_valid qualifies inst_out/pc_out; stall is the decoder's not-ready,
  // and while it is high the whole stage (including a presented word) is held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_e;

  fetchState_e       state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [ADDR_W-1:0] pcOutQ, pcOutNext;
  logic [INST_W-1:0] instOutQ, instOutNext;
  logic              instValidQ, instValidNext;
  logic              countInc;
  logic [15:0]       fetchCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      pcOutQ     <= '0;
      instOutQ   <= '0;
      instValidQ <= 1'b0;
      fetchCount <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      pcOutQ     <= pcOutNext;
      instOutQ   <= instOutNext;
      instValidQ <= instValidNext;
      if (countInc && fetchCount != 16'hFFFF) fetchCount <= fetchCount + 16'd1;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    pcOutNext     = pcOutQ;
    instOutNext   = instOutQ;
    instValidNext = instValidQ;
    countInc      = 1'b0;
    case (state)
      IDLE: begin
        instValidNext = 1'b0;
        if (start) begin
          pcNext    = start_addr;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (jump_valid) begin
            pcNext        = jump_addr;
            instValidNext = 1'b0;
          end else if (branch_taken) begin
            pcNext        = pcOutQ + branch_off;
            instValidNext = 1'b0;
          end else if (inst_in == HALT_INST) begin
            // pc stays on the halt word so a later restart can inspect it
            stateNext     = HALT;
            instValidNext = 1'b0;
          end else begin
            instOutNext   = inst_in;
            pcOutNext     = pc;
            instValidNext = 1'b1;
            countInc      = 1'b1;
            if (WRAP_HALT && pc == {ADDR_W{1'b1}}) stateNext = HALT;
            else pcNext = pc + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        instValidNext = 1'b0;
        if (start) begin
          pcNext    = start_addr;
          stateNext = RUN;
        end
      end
      default: begin
        stateNext     = IDLE;
        instValidNext = 1'b0;
      end
    endcase
  end

  assign inst_addr   = pc;
  assign inst_out    = instOutQ;
  assign inst_valid  = instValidQ;
  assign pc_out      = pcOutQ;
  assign halted      = (state == HALT);
  assign fetch_count = fetchCount;
  assign dbgState    = state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: scoreboard of expected {pc_out, inst_out} pairs
// drained by a monitor, plus direct checks of control/status at key cycles.
module tb_inst_fetch_unit;

  logic       clk;
  logic       rst_n;

  // DUT A: WRAP_HALT=1, fully driven
  logic       startA, stallA, jumpValidA, branchTakenA;
  logic [7:0] startAddrA, jumpAddrA, branchOffA, instAddrA, pcOutA;
  logic [9:0] instInA, instOutA;
  logic       instValidA, haltedA;
  logic [15:0] fetchCountA;
  logic [1:0] dbgStateA;
  logic [9:0] romA [256];

  // DUT B: WRAP_HALT=0, only started
  logic       startB, stallB, jumpValidB, branchTakenB;
  logic [7:0] startAddrB, jumpAddrB, branchOffB, instAddrB, pcOutB;
  logic [9:0] instInB, instOutB;
  logic       instValidB, haltedB;
  logic [15:0] fetchCountB;
  logic [1:0] dbgStateB;
  logic [9:0] romB [256];

  logic [17:0] exp_q[$];
  int          nVectors = 0;
  int          nMiscompares = 0;
  logic        edgeStalled = 1'b0;

  inst_fetch_unit #(.ADDR_W(8), .INST_W(10), .HALT_INST(10'd0), .WRAP_HALT(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .start_addr(startAddrA), .stall(stallA),
    .jump_valid(jumpValidA), .jump_addr(jumpAddrA), .branch_taken(branchTakenA),
    .branch_off(branchOffA), .inst_addr(instAddrA), .inst_in(instInA), .inst_out(instOutA),
    .inst_valid(instValidA), .pc_out(pcOutA), .halted(haltedA), .fetch_count(fetchCountA),
    .dbgState(dbgStateA)
  );

  inst_fetch_unit #(.ADDR_W(8), .INST_W(10), .HALT_INST(10'd0), .WRAP_HALT(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .start_addr(startAddrB), .stall(stallB),
    .jump_valid(jumpValidB), .jump_addr(jumpAddrB), .branch_taken(branchTakenB),
    .branch_off(branchOffB), .inst_addr(instAddrB), .inst_in(instInB), .inst_out(instOutB),
    .inst_valid(instValidB), .pc_out(pcOutB), .halted(haltedB), .fetch_count(fetchCountB),
    .dbgState(dbgStateB)
  );

  assign instInA = romA[instAddrA];
  assign instInB = romB[instAddrB];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) edgeStalled <= stallA;

  always @(negedge clk) begin
    if (instValidA && !edgeStalled) begin
      if (exp_q.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("FAIL unexpected_fetch: got pc_out %0h expected no valid word", pcOutA);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("fetch_pc", 32'(pcOutA), 32'(e[17:10]));
        check("fetch_inst", 32'(instOutA), 32'(e[9:0]));
      end
    end
  end

  // driver tasks
  task automatic pushPc(input logic [7:0] p);
    exp_q.push_back({p, 2'b01, p});
  endtask

  task automatic pushRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pushPc(8'(i));
  endtask

  task automatic pulseStartA(input logic [7:0] a);
    @(negedge clk);
    startA = 1'b1;
    startAddrA = a;
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic waitValidPc(input logic [7:0] p, input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (instValidA && pcOutA == p) found = 1'b1;
    end
    if (!found) begin
      nVectors++;
      nMiscompares++;
      $display("FAIL wait_pc: got no valid pc_out %0h expected within %0d cycles", p, budget);
    end
  endtask

  task automatic waitHalted(input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (haltedA) found = 1'b1;
    end
    if (!found) begin
      nVectors++;
      nMiscompares++;
      $display("FAIL wait_halt: got halted 0 expected 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    startA = 1'b0; stallA = 1'b0; jumpValidA = 1'b0; branchTakenA = 1'b0;
    startAddrA = '0; jumpAddrA = '0; branchOffA = '0;
    startB = 1'b0; stallB = 1'b0; jumpValidB = 1'b0; branchTakenB = 1'b0;
    startAddrB = '0; jumpAddrB = '0; branchOffB = '0;
    for (int i = 0; i < 256; i++) begin
      romA[i] = {2'b01, 8'(i)};
      romB[i] = {2'b01, 8'(i)};
    end
    romA[14] = 10'd0;

    // 1: reset state, then straight-line run into a halt word at 14
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(instValidA), 0);
    check("rst_pc_out", 32'(pcOutA), 0);
    check("rst_inst_out", 32'(instOutA), 0);
    check("rst_halted", 32'(haltedA), 0);
    check("rst_count", 32'(fetchCountA), 0);
    check("rst_addr", 32'(instAddrA), 0);
    check("rst_state", 32'(dbgStateA), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pushRange(0, 13);
    pulseStartA(8'h00);
    check("first_bubble", 32'(instValidA), 0);
    waitHalted(40);
    check("t1_addr", 32'(instAddrA), 14);
    check("t1_valid", 32'(instValidA), 0);
    check("t1_count", 32'(fetchCountA), 14);
    check("t1_drained", 32'(exp_q.size()), 0);

    // 2: jump at pc_out 3 to 8, branch at pc_out 10 by -5
    pushRange(0, 3); pushRange(8, 10); pushRange(5, 13);
    pulseStartA(8'h00);
    check("t2_restart_halted", 32'(haltedA), 0);
    waitValidPc(8'h03, 20);
    jumpValidA = 1'b1; jumpAddrA = 8'h08;
    @(negedge clk);
    jumpValidA = 1'b0;
    check("t2_jump_bubble", 32'(instValidA), 0);
    @(negedge clk);
    check("t2_jump_resume", 32'(instValidA), 1);
    waitValidPc(8'h0A, 20);
    branchTakenA = 1'b1; branchOffA = 8'hFB;
    @(negedge clk);
    branchTakenA = 1'b0;
    check("t2_branch_bubble", 32'(instValidA), 0);
    check("t2_branch_addr", 32'(instAddrA), 5);
    waitHalted(40);
    check("t2_count", 32'(fetchCountA), 30);
    check("t2_drained", 32'(exp_q.size()), 0);

    // 3: stall for 3 cycles with a pending jump
    pushRange(0, 1); pushRange(8, 13);
    pulseStartA(8'h00);
    waitValidPc(8'h01, 20);
    stallA = 1'b1; jumpValidA = 1'b1; jumpAddrA = 8'h08;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_pc_out", 32'(pcOutA), 1);
      check("t3_stall_inst", 32'(instOutA), 32'h101);
      check("t3_stall_addr", 32'(instAddrA), 2);
      check("t3_stall_valid", 32'(instValidA), 1);
      check("t3_stall_count", 32'(fetchCountA), 32);
    end
    stallA = 1'b0;
    @(negedge clk);
    jumpValidA = 1'b0;
    check("t3_jump_bubble", 32'(instValidA), 0);
    check("t3_jump_addr", 32'(instAddrA), 8);
    waitHalted(40);
    check("t3_count", 32'(fetchCountA), 38);
    check("t3_drained", 32'(exp_q.size()), 0);

    // 4: top of address space, halting and wrapping variants
    romA[14] = 10'h10E;
    pushPc(8'hFE); pushPc(8'hFF);
    pulseStartA(8'hFE);
    waitHalted(10);
    check("t4_final_valid", 32'(instValidA), 1);
    check("t4_final_pc", 32'(pcOutA), 32'hFF);
    @(negedge clk);
    check("t4_final_drop", 32'(instValidA), 0);
    check("t4_halted", 32'(haltedA), 1);
    check("t4_count", 32'(fetchCountA), 40);
    check("t4_drained", 32'(exp_q.size()), 0);
    @(negedge clk);
    startB = 1'b1; startAddrB = 8'hFE;
    @(negedge clk);
    startB = 1'b0;
    check("t4b_bubble", 32'(instValidB), 0);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] p;
      p = 8'hFE + 8'(i);
      @(negedge clk);
      check("t4b_valid", 32'(instValidB), 1);
      check("t4b_pc_out", 32'(pcOutB), 32'(p));
      check("t4b_inst", 32'(instOutB), 32'({2'b01, p}));
      check("t4b_halted", 32'(haltedB), 0);
    end

    // 5: asynchronous reset mid-run, then restart at 5
    romA[14] = 10'd0;
    pushRange(0, 3);
    pulseStartA(8'h00);
    waitValidPc(8'h03, 20);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(instValidA), 0);
    check("t5_pc_out", 32'(pcOutA), 0);
    check("t5_inst", 32'(instOutA), 0);
    check("t5_count", 32'(fetchCountA), 0);
    check("t5_addr", 32'(instAddrA), 0);
    check("t5_state", 32'(dbgStateA), 0);
    check("t5_b_valid", 32'(instValidB), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pushRange(5, 13);
    pulseStartA(8'h05);
    waitHalted(40);
    check("t5_count_after", 32'(fetchCountA), 9);
    check("t5_drained", 32'(exp_q.size()), 0);

    // 6: jump beats branch; jump target holds the halt word
    romA[8'h20] = 10'd0;
    pushRange(0, 2);
    pulseStartA(8'h00);
    waitValidPc(8'h02, 20);
    jumpValidA = 1'b1; jumpAddrA = 8'h20;
    branchTakenA = 1'b1; branchOffA = 8'h10;
    @(negedge clk);
    jumpValidA = 1'b0; branchTakenA = 1'b0;
    check("t6_bubble", 32'(instValidA), 0);
    check("t6_target", 32'(instAddrA), 32'h20);
    check("t6_not_halted", 32'(haltedA), 0);
    @(negedge clk);
    check("t6_halted", 32'(haltedA), 1);
    check("t6_valid", 32'(instValidA), 0);
    check("t6_pc", 32'(instAddrA), 32'h20);
    check("t6_state", 32'(dbgStateA), 2);
    check("t6_count", 32'(fetchCountA), 12);
    repeat (2) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
